// File: rtl/sorter_pkg.sv
// Types and constants shared by the bitonic sorter and its output drain.
package sorter_pkg;

    localparam int SORT_N = 8;

    typedef struct packed {
        logic valid;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } drain_state_t;

    // Requested element count clamped to 1..SORT_N.
    function automatic logic [3:0] eff_k(input logic [3:0] k);
        if (k == 4'd0)
            return 4'd1;
        else if (k > 4'(SORT_N))
            return 4'(SORT_N);
        else
            return k;
    endfunction

endpackage

// File: rtl/vec_fifo.sv
// Small FIFO of whole sorted vectors plus their effective element count.
// The head entry is read combinationally so the drain can stream it the cycle after capture.
module vec_fifo #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 wr_en_i,
    input  logic [DATAWIDTH-1:0] wr_data_i [DATALENGTH],
    input  logic [3:0]           wr_k_i,
    input  logic                 rd_en_i,
    output logic [DATAWIDTH-1:0] rd_data_o [DATALENGTH],
    output logic [3:0]           rd_k_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 one_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [AW:0]          w_count;
    logic [DATAWIDTH-1:0] r_mem [DEPTH][DATALENGTH];
    logic [3:0]           r_k   [DEPTH];

    // Payload storage carries no reset; only the pointers define occupancy.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
            r_k[r_wr_ptr[AW-1:0]]   <= wr_k_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en_i)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en_i)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign rd_data_o = r_mem[r_rd_ptr[AW-1:0]];
    assign rd_k_o    = r_k[r_rd_ptr[AW-1:0]];
    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign one_o     = (w_count == (AW+1)'(1));

endmodule

// File: rtl/bitonic_8_drain.sv
// Serializes sorted vectors from the bitonic backend, emitting the leading k elements
// of each vector one per transfer; vectors arriving while the buffer is full are dropped.
module bitonic_8_drain
    import sorter_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = SORT_N,
    parameter int DEPTH      = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  ctrl_t                ctrl_i,
    input  logic [DATAWIDTH-1:0] x_i [DATALENGTH],
    input  logic [3:0]           k_i,
    input  logic                 clr_i,
    input  logic                 ready_i,
    output logic [DATAWIDTH-1:0] y_o,
    output logic                 valid_o,
    output logic [2:0]           idx_o,
    output logic                 last_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    drain_state_t         r_state;
    drain_state_t         w_state_next;
    logic [2:0]           r_idx;
    logic                 r_overflow;
    logic [DATAWIDTH-1:0] w_head [DATALENGTH];
    logic [3:0]           w_head_k;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_one;
    logic                 w_xfer;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_drop;

    vec_fifo #(
        .DATAWIDTH  (DATAWIDTH),
        .DATALENGTH (DATALENGTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en_i   (w_capture),
        .wr_data_i (x_i),
        .wr_k_i    (eff_k(k_i)),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .rd_k_o    (w_head_k),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .one_o     (w_one)
    );

    always_comb begin
        w_state_next = r_state;
        valid_o      = (r_state == ST_STREAM);
        y_o          = '0;
        idx_o        = '0;
        last_o       = 1'b0;
        if (valid_o) begin
            y_o    = w_head[r_idx];
            idx_o  = r_idx;
            last_o = ({1'b0, r_idx} == (w_head_k - 4'd1));
        end
        w_xfer = valid_o && ready_i;
        w_pop  = w_xfer && last_o;
        // A full buffer still accepts when its head is leaving this very cycle.
        w_capture = ctrl_i.valid && (!w_full || w_pop);
        w_drop    = ctrl_i.valid && !w_capture;
        case (r_state)
            ST_IDLE:   if (w_capture) w_state_next = ST_STREAM;
            ST_STREAM: if (w_pop && w_one && !w_capture) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pop)
                r_idx <= '0;
            else if (w_xfer)
                r_idx <= r_idx + 3'd1;
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_i)
                r_overflow <= 1'b0;
        end
    end

    assign overflow_o = r_overflow;
    assign busy_o     = !w_empty;

endmodule

// File: tb/tb_bitonic_8_drain.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_bitonic_8_drain;
    import sorter_pkg::*;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rstn;
    ctrl_t      ctrl;
    logic [7:0] x [8];
    logic [3:0] k;
    logic       clr;
    logic       ready;
    logic [7:0] y_o;
    logic       valid_o;
    logic [2:0] idx_o;
    logic       last_o;
    logic       overflow_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;

    bitonic_8_drain #(
        .DATAWIDTH  (8),
        .DATALENGTH (8),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .ctrl_i     (ctrl),
        .x_i        (x),
        .k_i        (k),
        .clr_i      (clr),
        .ready_i    (ready),
        .y_o        (y_o),
        .valid_o    (valid_o),
        .idx_o      (idx_o),
        .last_o     (last_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bounded queue of vectors and the position within the head.
    logic [63:0] m_data [$];
    int          m_k    [$];
    int          m_idx = 0;
    bit          m_ovf = 0;

    always @(negedge clk) begin
        logic       e_valid;
        logic [7:0] e_y;
        logic       e_last;
        int         kk;
        bit         xfer, pop, cap;
        logic [63:0] v;
        if (!rstn) begin
            m_data.delete();
            m_k.delete();
            m_idx = 0;
            m_ovf = 0;
        end
        e_valid = (m_data.size() > 0);
        e_y     = e_valid ? m_data[0][m_idx*8 +: 8] : 8'd0;
        e_last  = e_valid && (m_idx == m_k[0] - 1);
        chk("valid", valid_o, e_valid);
        chk("y", y_o, e_y);
        chk("idx", idx_o, e_valid ? m_idx : 0);
        chk("last", last_o, e_last);
        chk("overflow", overflow_o, m_ovf);
        chk("busy", busy_o, e_valid);
        if (rstn) begin
            xfer = e_valid && ready;
            pop  = xfer && e_last;
            cap  = ctrl.valid && (m_data.size() < DEPTH || pop);
            if (pop) begin
                void'(m_data.pop_front());
                void'(m_k.pop_front());
                m_idx = 0;
            end else if (xfer) begin
                m_idx++;
            end
            if (cap) begin
                for (int j = 0; j < 8; j++) v[j*8 +: 8] = x[j];
                kk = (k == 0) ? 1 : ((k > 8) ? 8 : int'(k));
                m_data.push_back(v);
                m_k.push_back(kk);
            end
            if (ctrl.valid && !cap)
                m_ovf = 1;
            else if (clr)
                m_ovf = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec();
        for (int j = 0; j < 8; j++) x[j] = 8'($urandom);
    endtask

    initial begin
        int cnt;
        rstn = 1'b0;
        ctrl = '0;
        k = '0;
        clr = 1'b0;
        ready = 1'b0;
        for (int j = 0; j < 8; j++) x[j] = '0;
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        repeat (3) step();
        rstn = 1'b1;
        step();

        // Scenario 1: {9..2}, k=3
        for (int j = 0; j < 8; j++) x[j] = 8'(9 - j);
        k = 4'd3; ready = 1'b1; ctrl.valid = 1'b1;
        step();
        ctrl.valid = 1'b0;
        chk("s1_y0", y_o, 9); chk("s1_v0", valid_o, 1); chk("s1_i0", idx_o, 0);
        step();
        chk("s1_y1", y_o, 8); chk("s1_l1", last_o, 0);
        step();
        chk("s1_y2", y_o, 7); chk("s1_l2", last_o, 1);
        step();
        chk("s1_end", valid_o, 0);

        // Scenario 2: k clamping
        rand_vec(); k = 4'd0; ctrl.valid = 1'b1;
        step();
        ctrl.valid = 1'b0; cnt = 0;
        repeat (12) begin if (valid_o) cnt++; step(); end
        chk("s2_k0_count", cnt, 1);
        rand_vec(); k = 4'd12; ctrl.valid = 1'b1;
        step();
        ctrl.valid = 1'b0; cnt = 0;
        repeat (12) begin if (valid_o) cnt++; step(); end
        chk("s2_k12_count", cnt, 8);

        // Scenario 3: back-to-back vectors, k=2
        rand_vec(); k = 4'd2; ctrl.valid = 1'b1;
        step();
        rand_vec();
        chk("s3_i0", idx_o, 0); chk("s3_v0", valid_o, 1);
        step();
        ctrl.valid = 1'b0;
        chk("s3_i1", idx_o, 1); chk("s3_v1", valid_o, 1);
        step();
        chk("s3_i2", idx_o, 0); chk("s3_v2", valid_o, 1);
        step();
        chk("s3_i3", idx_o, 1); chk("s3_l3", last_o, 1);
        step();
        chk("s3_end", valid_o, 0);

        // Scenario 4: overflow with ready low, then clear
        ready = 1'b0; k = 4'd1; ctrl.valid = 1'b1; rand_vec();
        step();
        rand_vec();
        step();
        rand_vec();
        chk("s4_ovf_pre", overflow_o, 0);
        step();
        ctrl.valid = 1'b0;
        chk("s4_ovf_set", overflow_o, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("s4_ovf_clr", overflow_o, 0);
        chk("s4_busy", busy_o, 1);

        // Scenario 5: capture coincides with final transfer while full
        rand_vec(); ready = 1'b1; ctrl.valid = 1'b1;
        step();
        ctrl.valid = 1'b0;
        chk("s5_ovf", overflow_o, 0);
        chk("s5_busy", busy_o, 1);
        step();
        step();
        chk("s5_drained", valid_o, 0);

        // Scenario 6: reset mid-vector at idx 2
        rand_vec(); k = 4'd8; ctrl.valid = 1'b1;
        step();
        ctrl.valid = 1'b0;
        chk("s6_i0", idx_o, 0);
        step();
        step();
        chk("s6_i2", idx_o, 2);
        rstn = 1'b0;
        #1;
        chk("s6_rst_valid", valid_o, 0);
        chk("s6_rst_y", y_o, 0);
        chk("s6_rst_idx", idx_o, 0);
        chk("s6_rst_busy", busy_o, 0);
        step();
        step();
        rstn = 1'b1;
        repeat (3) begin
            step();
            chk("s6_post_valid", valid_o, 0);
        end

        // Randomized traffic
        repeat (3000) begin
            rand_vec();
            k          = 4'($urandom_range(0, 15));
            ctrl.valid = ($urandom_range(0, 1) == 1);
            ready      = ($urandom_range(0, 9) < 7);
            clr        = ($urandom_range(0, 19) == 0);
            step();
        end
        ctrl.valid = 1'b0; clr = 1'b0; ready = 1'b1;
        repeat (40) step();
        chk("final_idle", valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
